// File: rtl/draw_sprite_if.sv
// Video timing/colour bundle (vga_if) and sprite position bundle (pos_if)
// shared by the draw stages of the VGA pipeline.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

interface pos_if;
  logic [10:0] x;
  logic [10:0] y;

  modport out (output x, y);
  modport in  (input  x, y);
endinterface

// File: rtl/draw_sprite.sv
// Sprite overlay stage: animated, mirrorable sprite read from an external synchronous ROM.
// Define SPRITE_SCALE2_EN to show the sprite at 2x (ROM layout and 3-clk latency unchanged).
module draw_sprite #(
  parameter int unsigned SPR_W     = 32,
  parameter int unsigned SPR_H     = 32,
  parameter int unsigned FRAMES    = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter int unsigned ANIM_DIV  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       sprite_x,
  input  logic [10:0]       sprite_y,
  input  logic              flip,
  input  logic              anim_en,
  input  logic [11:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  vga_if.in                 in,
  vga_if.out                out,
  pos_if.out                player_pos
);

`ifdef SPRITE_SCALE2_EN
  localparam int unsigned SHIFT = 1;
`else
  localparam int unsigned SHIFT = 0;
`endif

  localparam logic [11:0] WIN_W = 12'(SPR_W << SHIFT);
  localparam logic [11:0] WIN_H = 12'(SPR_H << SHIFT);
  localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
  localparam logic [ANIM_W-1:0]  ANIM_LAST  = ANIM_W'(ANIM_DIV - 1);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // Offsets are only meaningful inside the window; the scale shift comes before the mirror.
  function automatic logic [ADDR_W-1:0] sprite_addr(
    input logic [10:0]        dx,
    input logic [10:0]        dy,
    input logic               mirror,
    input logic [FRAME_W-1:0] frame
  );
    logic [31:0] col;
    logic [31:0] row;
    logic [31:0] base;
    col = 32'(dx) >> SHIFT;
    if (mirror) col = 32'(SPR_W - 1) - col;
    row  = 32'(dy) >> SHIFT;
    base = 32'(frame) * 32'(SPR_W * SPR_H);
    return ADDR_W'(base + row * 32'(SPR_W) + col);
  endfunction

  logic               vblnk_q, vblnk_d;
  logic               armed_q, armed_d;
  logic               vblnk_rise;
  logic [10:0]        x_q, x_d;
  logic [10:0]        y_q, y_d;
  logic               flip_q, flip_d;
  logic [ANIM_W-1:0]  anim_cnt_q, anim_cnt_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;

  // armed_q keeps a vblank already in progress at reset release from counting as a rise.
  always_comb begin
    vblnk_d     = in.vblnk;
    armed_d     = armed_q | ~in.vblnk;
    vblnk_rise  = in.vblnk & ~vblnk_q & armed_q;
    x_d         = x_q;
    y_d         = y_q;
    flip_d      = flip_q;
    anim_cnt_d  = anim_cnt_q;
    frame_idx_d = frame_idx_q;
    if (vblnk_rise) begin
      x_d    = sprite_x;
      y_d    = sprite_y;
      flip_d = flip;
    end
    if (!anim_en) begin
      anim_cnt_d  = '0;
      frame_idx_d = '0;
    end else if (vblnk_rise) begin
      if (anim_cnt_q == ANIM_LAST) begin
        anim_cnt_d  = '0;
        frame_idx_d = (frame_idx_q == FRAME_LAST) ? '0 : frame_idx_q + 1'b1;
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      armed_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      flip_q      <= 1'b0;
      anim_cnt_q  <= '0;
      frame_idx_q <= '0;
    end else begin
      vblnk_q     <= vblnk_d;
      armed_q     <= armed_d;
      x_q         <= x_d;
      y_q         <= y_d;
      flip_q      <= flip_d;
      anim_cnt_q  <= anim_cnt_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  // Stage 0: window test and ROM address on the incoming pixel
  vga_t              vga_p0;
  logic              hit_p0;
  logic [11:0]       hc_p0, vc_p0, x_lo_p0, y_lo_p0;
  logic [ADDR_W-1:0] rom_addr_p1_d;

  always_comb begin
    vga_p0.hcount = in.hcount;
    vga_p0.vcount = in.vcount;
    vga_p0.hsync  = in.hsync;
    vga_p0.vsync  = in.vsync;
    vga_p0.hblnk  = in.hblnk;
    vga_p0.vblnk  = in.vblnk;
    vga_p0.rgb    = in.rgb;
    hc_p0   = {1'b0, in.hcount};
    vc_p0   = {1'b0, in.vcount};
    x_lo_p0 = {1'b0, x_q};
    y_lo_p0 = {1'b0, y_q};
    hit_p0  = (hc_p0 >= x_lo_p0) && (hc_p0 < x_lo_p0 + WIN_W) &&
              (vc_p0 >= y_lo_p0) && (vc_p0 < y_lo_p0 + WIN_H);
    rom_addr_p1_d = hit_p0 ? sprite_addr(in.hcount - x_q, in.vcount - y_q, flip_q, frame_idx_q)
                           : '0;
  end

  // Stage 1/2: carry timing and hit alongside the ROM read
  vga_t              vga_p1_q, vga_p1_d;
  vga_t              vga_p2_q, vga_p2_d;
  logic              hit_p1_q, hit_p1_d;
  logic              hit_p2_q, hit_p2_d;
  logic [ADDR_W-1:0] rom_addr_p1_q;

  always_comb begin
    vga_p1_d = vga_p0;
    hit_p1_d = hit_p0;
    vga_p2_d = vga_p1_q;
    hit_p2_d = hit_p1_q;
  end

  always_ff @(posedge clk) begin
    vga_p1_q <= vga_p1_d;
    vga_p2_q <= vga_p2_d;
  end

  // Stage 3: merge the ROM pixel over the delayed background
  vga_t out_p3_q, out_p3_d;

  always_comb begin
    out_p3_d = vga_p2_q;
    if (hit_p2_q && (rom_data != KEY_COLOR)) out_p3_d.rgb = rom_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_p1_q      <= 1'b0;
      hit_p2_q      <= 1'b0;
      rom_addr_p1_q <= '0;
      out_p3_q      <= '0;
    end else begin
      hit_p1_q      <= hit_p1_d;
      hit_p2_q      <= hit_p2_d;
      rom_addr_p1_q <= rom_addr_p1_d;
      out_p3_q      <= out_p3_d;
    end
  end

  assign rom_addr     = rom_addr_p1_q;
  assign out.hcount   = out_p3_q.hcount;
  assign out.vcount   = out_p3_q.vcount;
  assign out.hsync    = out_p3_q.hsync;
  assign out.vsync    = out_p3_q.vsync;
  assign out.hblnk    = out_p3_q.hblnk;
  assign out.vblnk    = out_p3_q.vblnk;
  assign out.rgb      = out_p3_q.rgb;
  assign player_pos.x = x_q;
  assign player_pos.y = y_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: directed scenarios plus randomized pixels checked
// against a window/address/animation reference model.
module tb_draw_sprite;
  localparam int SPR_W = 32, SPR_H = 32, FRAMES = 4, ADDR_W = 12, ANIM_DIV = 8;
  localparam logic [11:0] KEY = 12'hF0F;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [10:0]       sprite_x = '0, sprite_y = '0;
  logic              flip = 1'b0, anim_en = 1'b0;
  logic [11:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: position latched at the last vblank rise, rises since anim enabled
  int m_x = 0, m_y = 0, m_rises = 0;
  bit m_flip = 0;

  vga_if vin ();
  vga_if vout ();
  pos_if ppos ();

  draw_sprite #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .ADDR_W(ADDR_W),
                .KEY_COLOR(KEY), .ANIM_DIV(ANIM_DIV)) dut (
    .clk(clk), .rst(rst), .sprite_x(sprite_x), .sprite_y(sprite_y), .flip(flip),
    .anim_en(anim_en), .rom_data(rom_data), .rom_addr(rom_addr),
    .in(vin), .out(vout), .player_pos(ppos));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  function automatic bit m_hit(int h, int v);
    return h >= m_x && h < m_x + SPR_W && v >= m_y && v < m_y + SPR_H;
  endfunction

  function automatic int m_addr(int h, int v);
    int col, row, frame;
    if (!m_hit(h, v)) return 0;
    col = h - m_x;
    if (m_flip) col = SPR_W - 1 - col;
    row = v - m_y;
    frame = (m_rises / ANIM_DIV) % FRAMES;
    return (frame * SPR_W * SPR_H + row * SPR_W + col) % (1 << ADDR_W);
  endfunction

  function automatic logic [11:0] m_rgb(int h, int v, logic [11:0] bg);
    int a;
    if (!m_hit(h, v)) return bg;
    a = m_addr(h, v);
    return (mem[a] == KEY) ? bg : mem[a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int h, input int v, input logic [11:0] c);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.rgb    = c;
    vin.vblnk  = 1'b0;
    vin.hblnk  = 1'($urandom);
    vin.hsync  = 1'($urandom);
    vin.vsync  = 1'($urandom);
  endtask

  task automatic do_vblank();
    set_pix(2047, 2047, 12'h000);
    vin.vblnk = 1'b1;
    step();
    m_x = sprite_x; m_y = sprite_y; m_flip = flip;
    if (anim_en) m_rises++;
    vin.vblnk = 1'b0;
    step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++; if (vout.rgb !== 12'h000) begin n_errors++; $display("FAIL reset_rgb: got %h want 000", vout.rgb); end
    n_checks++; if (vout.hcount !== 11'd0) begin n_errors++; $display("FAIL reset_hcount: got %0d want 0", vout.hcount); end
    n_checks++; if (rom_addr !== 12'd0) begin n_errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    n_checks++; if (ppos.x !== 11'd0) begin n_errors++; $display("FAIL reset_pos_x: got %0d want 0", ppos.x); end
    n_checks++; if (ppos.y !== 11'd0) begin n_errors++; $display("FAIL reset_pos_y: got %0d want 0", ppos.y); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_latency();
    sprite_x = 11'd100; sprite_y = 11'd50; flip = 1'b0; anim_en = 1'b0;
    mem[0] = 12'h123;
    do_vblank();
    n_checks++; if (ppos.x !== 11'd100) begin n_errors++; $display("FAIL lat_pos_x: got %0d want 100", ppos.x); end
    set_pix(100, 50, 12'h456);
    step();
    n_checks++; if (rom_addr !== 12'd0) begin n_errors++; $display("FAIL lat_rom_addr: got %0d want 0", rom_addr); end
    set_pix(2047, 2047, 12'h000);
    step();
    n_checks++; if (vout.hcount === 11'd100) begin n_errors++; $display("FAIL lat_early: got hcount %0d at 2 clk, want not 100", vout.hcount); end
    step();
    n_checks++; if (vout.rgb !== 12'h123) begin n_errors++; $display("FAIL lat_rgb: got %h want 123", vout.rgb); end
    n_checks++; if (vout.hcount !== 11'd100) begin n_errors++; $display("FAIL lat_hcount: got %0d want 100", vout.hcount); end
    n_checks++; if (vout.vcount !== 11'd50) begin n_errors++; $display("FAIL lat_vcount: got %0d want 50", vout.vcount); end
  endtask

  task automatic test_flip_edges();
    int ph[4] = '{100, 131, 99, 132};
    int pv[4] = '{50, 51, 50, 50};
    int ea[4] = '{31, 32, 0, 0};
    logic [11:0] er[4];
    logic [11:0] c;
    sprite_x = 11'd100; sprite_y = 11'd50; flip = 1'b1;
    do_vblank();
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        c = 12'($urandom);
        if (c == KEY) c = 12'h001;
        set_pix(ph[j], pv[j], c);
        er[j] = (j >= 2) ? c : m_rgb(ph[j], pv[j], c);
      end else set_pix(2047, 2047, 12'h000);
      step();
      if (j < 4) begin
        n_checks++; if (rom_addr !== ADDR_W'(ea[j])) begin n_errors++; $display("FAIL flip_addr[%0d]: got %0d want %0d", j, rom_addr, ea[j]); end
      end
      if (j >= 2) begin
        n_checks++; if (vout.rgb !== er[j-2]) begin n_errors++; $display("FAIL flip_rgb[%0d]: got %h want %h", j-2, vout.rgb, er[j-2]); end
      end
    end
  endtask

  task automatic test_transparency();
    int ph[2] = '{105, 106};
    logic [11:0] er[2] = '{12'h00A, 12'hF0E};
    sprite_x = 11'd100; sprite_y = 11'd50; flip = 1'b0;
    mem[5] = 12'hF0F; mem[6] = 12'hF0E;
    do_vblank();
    for (int j = 0; j < 4; j++) begin
      if (j < 2) set_pix(ph[j], 50, 12'h00A);
      else set_pix(2047, 2047, 12'h000);
      step();
      if (j >= 2) begin
        n_checks++; if (vout.rgb !== er[j-2]) begin n_errors++; $display("FAIL transp_rgb[%0d]: got %h want %h", j-2, vout.rgb, er[j-2]); end
      end
    end
  endtask

  task automatic test_tear_free();
    sprite_x = 11'd100; sprite_y = 11'd50; flip = 1'b0;
    do_vblank();
    sprite_x = 11'd200;
    set_pix(120, 50, 12'h000);
    step();
    n_checks++; if (rom_addr !== 12'd20) begin n_errors++; $display("FAIL tear_addr_old: got %0d want 20", rom_addr); end
    n_checks++; if (ppos.x !== 11'd100) begin n_errors++; $display("FAIL tear_pos_old: got %0d want 100", ppos.x); end
    do_vblank();
    n_checks++; if (ppos.x !== 11'd200) begin n_errors++; $display("FAIL tear_pos_new: got %0d want 200", ppos.x); end
    set_pix(220, 50, 12'h000);
    step();
    n_checks++; if (rom_addr !== 12'd20) begin n_errors++; $display("FAIL tear_addr_new: got %0d want 20", rom_addr); end
    set_pix(120, 50, 12'h000);
    step();
    n_checks++; if (rom_addr !== 12'd0) begin n_errors++; $display("FAIL tear_addr_stale: got %0d want 0", rom_addr); end
  endtask

  task automatic test_animation();
    int ev[4] = '{1025, 2049, 1, 1025};
    int nv[4] = '{8, 8, 16, 8};
    sprite_x = 11'd100; sprite_y = 11'd50; flip = 1'b0;
    anim_en = 1'b1; m_rises = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      repeat (nv[k]) do_vblank();
      set_pix(101, 50, 12'h000);
      step();
      n_checks++; if (rom_addr !== ADDR_W'(ev[k])) begin n_errors++; $display("FAIL anim_addr[%0d]: got %0d want %0d (rises %0d)", k, rom_addr, ev[k], m_rises); end
      n_checks++; if (rom_addr !== ADDR_W'(m_addr(101, 50))) begin n_errors++; $display("FAIL anim_model[%0d]: got %0d want %0d", k, rom_addr, m_addr(101, 50)); end
    end
    anim_en = 1'b0; m_rises = 0;
    set_pix(2047, 2047, 12'h000);
    step();
    set_pix(101, 50, 12'h000);
    step();
    n_checks++; if (rom_addr !== 12'd1) begin n_errors++; $display("FAIL anim_off_addr: got %0d want 1", rom_addr); end
  endtask

  task automatic test_random_window();
    int eh[64], ea[64];
    logic [11:0] er[64];
    logic es[64];
    int h, v;
    anim_en = 1'b0; m_rises = 0;
    for (int blk = 0; blk < 6; blk++) begin
      sprite_x = 11'($urandom_range(0, 600));
      sprite_y = 11'($urandom_range(0, 400));
      flip = 1'($urandom);
      do_vblank();
      for (int j = 0; j < 42; j++) begin
        if (j < 40) begin
          h = m_x + int'($urandom_range(0, SPR_W + 8)) - 4; if (h < 0) h = 0;
          v = m_y + int'($urandom_range(0, SPR_H + 8)) - 4; if (v < 0) v = 0;
          set_pix(h, v, 12'($urandom));
          ea[j] = m_addr(h, v); er[j] = m_rgb(h, v, vin.rgb); eh[j] = h; es[j] = vin.hsync;
        end else set_pix(2047, 2047, 12'h000);
        step();
        if (j < 40) begin
          n_checks++; if (rom_addr !== ADDR_W'(ea[j])) begin n_errors++; $display("FAIL rand_addr[%0d.%0d]: got %0d want %0d", blk, j, rom_addr, ea[j]); end
        end
        if (j >= 2) begin
          n_checks++; if (vout.rgb !== er[j-2]) begin n_errors++; $display("FAIL rand_rgb[%0d.%0d]: got %h want %h", blk, j-2, vout.rgb, er[j-2]); end
          n_checks++; if (vout.hcount !== 11'(eh[j-2])) begin n_errors++; $display("FAIL rand_hcount[%0d.%0d]: got %0d want %0d", blk, j-2, vout.hcount, eh[j-2]); end
          n_checks++; if (vout.hsync !== es[j-2]) begin n_errors++; $display("FAIL rand_hsync[%0d.%0d]: got %b want %b", blk, j-2, vout.hsync, es[j-2]); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int eh[16];
    logic [11:0] er[16];
    int h, v;
    anim_en = 1'b0;
    sprite_x = 11'd100; sprite_y = 11'd50; flip = 1'b0;
    do_vblank();
    for (int j = 0; j < 3; j++) begin set_pix(100 + j, 50, 12'h0F0); step(); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (vout.rgb !== 12'h000) begin n_errors++; $display("FAIL areset_rgb: got %h want 000", vout.rgb); end
    n_checks++; if (rom_addr !== 12'd0) begin n_errors++; $display("FAIL areset_rom_addr: got %0d want 0", rom_addr); end
    n_checks++; if (ppos.x !== 11'd0) begin n_errors++; $display("FAIL areset_pos_x: got %0d want 0", ppos.x); end
    n_checks++; if (ppos.y !== 11'd0) begin n_errors++; $display("FAIL areset_pos_y: got %0d want 0", ppos.y); end
    set_pix(2047, 2047, 12'h000);
    vin.vblnk = 1'b1;
    sprite_x = 11'd300; sprite_y = 11'd20;
    step();
    rst = 1'b0;
    m_x = 0; m_y = 0; m_flip = 0; m_rises = 0;
    repeat (3) step();
    n_checks++; if (ppos.x !== 11'd0) begin n_errors++; $display("FAIL areset_no_rise: got %0d want 0", ppos.x); end
    for (int j = 0; j < 12; j++) begin
      if (j < 10) begin
        h = int'($urandom_range(0, 40)); v = int'($urandom_range(0, 40));
        set_pix(h, v, 12'($urandom));
        er[j] = m_rgb(h, v, vin.rgb); eh[j] = h;
      end else set_pix(2047, 2047, 12'h000);
      step();
      if (j >= 2) begin
        n_checks++; if (vout.rgb !== er[j-2]) begin n_errors++; $display("FAIL areset_rgb[%0d]: got %h want %h", j-2, vout.rgb, er[j-2]); end
        n_checks++; if (vout.hcount !== 11'(eh[j-2])) begin n_errors++; $display("FAIL areset_hcount[%0d]: got %0d want %0d", j-2, vout.hcount, eh[j-2]); end
      end
    end
    do_vblank();
    n_checks++; if (ppos.x !== 11'd300) begin n_errors++; $display("FAIL areset_pos_after: got %0d want 300", ppos.x); end
    n_checks++; if (ppos.y !== 11'd20) begin n_errors++; $display("FAIL areset_posy_after: got %0d want 20", ppos.y); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = ($urandom % 5 == 0) ? KEY : 12'($urandom);
    set_pix(2047, 2047, 12'h000);
    test_reset();
    test_latency();
    test_flip_edges();
    test_transparency();
    test_tear_free();
    test_animation();
    test_random_window();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/draw_sprite.md
Name: draw_sprite

Overview:
Parametrised sprite overlay stage for the VGA pipeline. It generalises the fixed single-character drawer to any sprite size, multi-frame animation, horizontal mirroring and tear-free position latching. It sits in the vga_if chain after the background and other draw stages and drives an external synchronous sprite ROM. It also republishes the sprite's latched position on pos_if for game logic.

Parameters:
SPR_W, 32, sprite width in pixels (power of two)
SPR_H, 32, sprite height in pixels
FRAMES, 4, number of animation frames stored back to back in the ROM
ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= FRAMES*SPR_W*SPR_H
KEY_COLOR, 12'hF0F, transparent colour; matching ROM pixels show the underlying rgb
ANIM_DIV, 8, number of video frames per animation step

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
sprite_x  in  11  requested left edge (screen pixels)
sprite_y  in  11  requested top edge
flip  in  1  1 = mirror sprite horizontally
anim_en  in  1  1 = cycle animation frames
rom_data  in  12  ROM pixel; valid one clk after rom_addr
rom_addr  out  ADDR_W  ROM read address
in  vga_if.in  -  upstream timing + rgb
out  vga_if.out  -  downstream timing + rgb
player_pos  pos_if.out  -  latched sprite x/y

Behaviour:
- Reset (async, active-high): all out.* fields, rom_addr, player_pos.x/y, latched x/y/flip, frame_idx, anim counter and vblnk edge register go to 0 immediately.
- Position latch: vblnk_rise = in.vblnk & ~vblnk_q. On vblnk_rise, capture sprite_x, sprite_y and flip into x_q, y_q and flip_q. All drawing uses the latched values, so a mid-frame change takes effect at the next vblnk rise. player_pos.x/y = x_q/y_q, truncated to the pos_if width.
- If reset releases while vblnk is high, there is no rise until the next vblank.
- Animation: when anim_en=1, each vblnk_rise increments anim_cnt. When anim_cnt reaches ANIM_DIV-1 it wraps to 0 and frame_idx increments modulo FRAMES (FRAMES-1 -> 0).
- When anim_en=0, anim_cnt and frame_idx are held at 0 and updated synchronously on the next clk.
- Window test (stage 0, combinational on in.*): hit = hcount>=x_q && hcount<x_q+SPR_W && vcount>=y_q && vcount<y_q+SPR_H. The additions are done in 12 bits, so windows extending past 2047 do not wrap.
- Address calculation:
  - col = hcount-x_q; if flip_q, col = SPR_W-1-col.
  - row = vcount-y_q.
  - addr = frame_idx*SPR_W*SPR_H + row*SPR_W + col, truncated to ADDR_W.
  - rom_addr <= hit ? addr : 0 (registered, stage 1).
- Pipeline:
  - in.* and hit are delayed 2 clk, aligning with rom_data.
  - Output register: out.rgb = (hit_d2 && rom_data != KEY_COLOR) ? rom_data : rgb_d2. The other timing fields pass through unchanged.
  - Total latency from in to out is 3 clk for every field.
- Blanking: there is no special case. A sprite inside the blanking region is drawn into rgb, and downstream blanking handles it.
- A sprite partly off-screen is clipped naturally, because out-of-range hcount/vcount never occur.

Optional Feature:
SPRITE_SCALE2_EN: when defined, the sprite is displayed at 2x.
- The window becomes 2*SPR_W by 2*SPR_H.
- col = (hcount-x_q)>>1, row = (vcount-y_q)>>1; flip is applied after the shift.
- The ROM is unchanged and latency stays 3 clk.
When undefined, the sprite is drawn 1:1 as described above.

Test Plan:
- Latency and alignment: x=100, y=50, flip=0, anim_en=0, pixel (100,50) -> rom_addr=0 after 1 clk; rom_data=12'h123 -> out.rgb=12'h123 exactly 3 clk after input; out.hcount=100 in the same cycle.
- Flip and window edges: flip=1, pixel (100,50) -> rom_addr=31; (131,51) -> rom_addr=32; (99,50) and (132,50) -> rom_addr=0 and out.rgb = input rgb.
- Transparency: inside the window with rom_data=12'hF0F and bg rgb=12'h00A -> out.rgb=12'h00A; rom_data=12'hF0E -> out.rgb=12'hF0E.
- Animation: anim_en=1, ANIM_DIV=8 -> after 8 vblnk rises, pixel (x_q,y_q) gives rom_addr=1024; after 32 rises it wraps to 0; dropping anim_en -> next pixel address base 0.
- Tear-free latch: change sprite_x from 100 to 200 mid-frame -> drawing and player_pos.x stay 100 until the next vblnk rise, then 200.
- Async reset: assert rst mid-line between clock edges -> out.rgb, rom_addr and player_pos are 0 before the next clk edge; after release, first output matches the 3-clk delayed input.
